// File: rtl/return_stack.sv
// ============================================================================
// Module   : return_stack
// Purpose  : Hardware return-address stack for the single-cycle CPU. Accepts
//            push/pop strobes from the control unit and the return address
//            from the PC incrementer; presents the top entry combinationally
//            so the PC can load it on the same edge that pops it. Sticky
//            overflow/underflow flags report rejected operations for debug.
// Ports    : clk       - system clock, rising edge
//            reset     - asynchronous active-high reset
//            push      - push ret_addr at the next rising edge
//            pop       - pop the top entry at the next rising edge
//            ret_addr  - address to push (WIDTH bits)
//            clr_err   - synchronous clear of the sticky error flags
//            top       - current top entry, 0 when empty (combinational)
//            empty     - no valid entries
//            full      - DEPTH valid entries
//            level     - number of valid entries
//            overflow  - sticky: a push was rejected on a full stack
//            underflow - sticky: a pop hit an empty stack
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module return_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           ret_addr,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           top,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_sp;
  logic             r_overflow;
  logic             r_underflow;

  logic [PW-1:0]    w_sp_m1;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_we;
  logic [PW-1:0]    w_sp_next;
  logic             w_ovf_event;
  logic             w_unf_event;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == C_DEPTH);
  assign w_sp_m1   = r_sp - 1'b1;
  assign w_top_idx = w_sp_m1[AW-1:0];

  // Top is read straight from the array so it is valid in the pop cycle.
  assign top       = w_empty ? '0 : r_mem[w_top_idx];
  assign empty     = w_empty;
  assign full      = w_full;
  assign level     = r_sp;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  always_comb begin
    w_we        = 1'b0;
    w_wr_idx    = r_sp[AW-1:0];
    w_sp_next   = r_sp;
    w_ovf_event = 1'b0;
    w_unf_event = 1'b0;
    if (push && pop) begin
      w_we = 1'b1;
      if (w_empty) begin
        // Simultaneous strobes on an empty stack degrade to a plain push.
        w_wr_idx  = '0;
        w_sp_next = PW'(1);
      end else begin
        // Replace the top entry in place.
        w_wr_idx = w_top_idx;
      end
    end else if (push) begin
      if (w_full) begin
        w_ovf_event = 1'b1;
      end else begin
        w_we      = 1'b1;
        w_sp_next = r_sp + 1'b1;
      end
    end else if (pop) begin
      if (w_empty) begin
        w_unf_event = 1'b1;
      end else begin
        w_sp_next = w_sp_m1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_sp <= w_sp_next;
      // An error event in the same cycle as clr_err keeps the flag set.
      if (w_ovf_event)  r_overflow  <= 1'b1;
      else if (clr_err) r_overflow  <= 1'b0;
      if (w_unf_event)  r_underflow <= 1'b1;
      else if (clr_err) r_underflow <= 1'b0;
    end
  end

  // Array is not reset; contents are unobservable while the stack is empty.
  // Writes are suppressed on any edge where reset is held.
  always_ff @(posedge clk) begin
    if (w_we && !reset) begin
      r_mem[w_wr_idx] <= ret_addr;
    end
  end

endmodule

`default_nettype wire
